// File: rtl/seq_mod_updown_counter_pkg.sv
// Shared types and default sizes for the modulus up/down counter family.
package seq_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int SEQ_WIDTH_DEF  = 8;
    localparam int SEQ_STEP_W_DEF = 4;

endpackage

// File: rtl/seq_cnt_next.sv
// Next-state arithmetic for the modulus counter: one enabled step from the
// current count, including out-of-range recovery and wrap/saturate handling.
module seq_cnt_next
    import seq_pkg::*;
#(
    parameter int WIDTH  = SEQ_WIDTH_DEF,
    parameter int STEP_W = SEQ_STEP_W_DEF
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic              up,
    input  cnt_mode_e         mode,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  next_count,
    output logic              evt_next
);

    localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] cnt_w_s;
    logic [WIDTH:0] step_w_s;
    logic [WIDTH:0] lim_w_s;
    logic [WIDTH:0] span_s;
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] wrap_up_s;
    logic [WIDTH:0] deficit_s;
    logic [WIDTH:0] wrap_dn_s;

    assign cnt_w_s   = {1'b0, count};
    assign step_w_s  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign lim_w_s   = {1'b0, limit};
    assign span_s    = lim_w_s + ONE_W;  // modulus, fits because limit < 2**WIDTH
    assign sum_s     = cnt_w_s + step_w_s;
    assign wrap_up_s = sum_s - span_s;
    assign deficit_s = step_w_s - cnt_w_s;
    assign wrap_dn_s = span_s - deficit_s;

    // Select the stepped value; a single wrap is applied, larger overshoots clamp
    always_comb begin
        next_count = count;
        evt_next   = 1'b0;
        if (cnt_w_s > lim_w_s) begin
            evt_next   = 1'b1;
            next_count = (mode == CNT_SAT) ? limit : {WIDTH{1'b0}};
        end else if (up) begin
            if (sum_s <= lim_w_s) begin
                next_count = sum_s[WIDTH-1:0];
            end else begin
                evt_next = 1'b1;
                case (mode)
                    CNT_SAT:  next_count = limit;
                    CNT_WRAP: next_count = (wrap_up_s <= lim_w_s) ? wrap_up_s[WIDTH-1:0] : limit;
                    default:  next_count = limit;
                endcase
            end
        end else begin
            if (step_w_s <= cnt_w_s) begin
                next_count = count - step_w_s[WIDTH-1:0];
            end else begin
                evt_next = 1'b1;
                case (mode)
                    CNT_SAT:  next_count = {WIDTH{1'b0}};
                    CNT_WRAP: next_count = (deficit_s <= span_s) ? wrap_dn_s[WIDTH-1:0] : {WIDTH{1'b0}};
                    default:  next_count = {WIDTH{1'b0}};
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_mod_updown_counter.sv
// Programmable-modulus up/down counter with load, wrap/saturate mode and
// boundary event pulse plus sticky flag.
module seq_mod_updown_counter
    import seq_pkg::*;
#(
    parameter int WIDTH  = SEQ_WIDTH_DEF,
    parameter int STEP_W = SEQ_STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic              mode,
    input  logic [WIDTH-1:0]  limit,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_evt,
    output logic [WIDTH-1:0]  count,
    output logic              evt,
    output logic              evt_sticky,
    output logic              at_max,
    output logic              at_min
);

    logic [WIDTH-1:0] count_r;
    logic             evt_r;
    logic             sticky_r;
    logic [WIDTH-1:0] step_count_s;
    logic             step_evt_s;
    logic [WIDTH-1:0] count_d_s;
    logic             evt_d_s;
    logic             sticky_d_s;

    seq_cnt_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .count      (count_r),
        .step       (step),
        .up         (up),
        .mode       (cnt_mode_e'(mode)),
        .limit      (limit),
        .next_count (step_count_s),
        .evt_next   (step_evt_s)
    );

    // Load beats enable; a loaded value is clamped into the legal range
    always_comb begin
        count_d_s = count_r;
        evt_d_s   = 1'b0;
        if (load) begin
            count_d_s = (load_val > limit) ? limit : load_val;
            evt_d_s   = 1'b0;
        end else if (en) begin
            count_d_s = step_count_s;
            evt_d_s   = step_evt_s;
        end else begin
            count_d_s = count_r;
            evt_d_s   = 1'b0;
        end
        sticky_d_s = evt_d_s | (sticky_r & ~clr_evt);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= {WIDTH{1'b0}};
            evt_r    <= 1'b0;
            sticky_r <= 1'b0;
        end else begin
            count_r  <= count_d_s;
            evt_r    <= evt_d_s;
            sticky_r <= sticky_d_s;
        end
    end

    assign count      = count_r;
    assign evt        = evt_r;
    assign evt_sticky = sticky_r;
    assign at_max     = (count_r == limit);
    assign at_min     = (count_r == {WIDTH{1'b0}});

endmodule

// File: doc/seq_mod_updown_counter.md
Name: seq_mod_updown_counter

Overview:
Parametrised up/down counter with programmable modulus (limit), programmable step, parallel load, and a runtime wrap/saturate mode. It generalises the team's fixed-step free-running and up/down counter exercises. It is intended as a reusable timer/index generator for later sequential tutorial blocks. Boundary crossings produce a one-cycle event pulse and a sticky flag.

Parameters:
WIDTH, 8, counter and limit width in bits (>=2)
STEP_W, 4, step input width in bits (1..WIDTH)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  count enable for one step this cycle
up  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment/decrement amount (zero-extended)
mode  input  1  cnt_mode_e: 0 = CNT_WRAP, 1 = CNT_SAT
limit  input  WIDTH  inclusive maximum; legal range is 0..limit
load  input  1  parallel load request
load_val  input  WIDTH  value to load
clr_evt  input  1  clears evt_sticky
count  output  WIDTH  current count (registered)
evt  output  1  registered one-cycle pulse on boundary event
evt_sticky  output  1  registered sticky OR of evt
at_max  output  1  combinational: count == limit
at_min  output  1  combinational: count == 0

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: count=0, evt=0, evt_sticky=0. rst has priority over every other input.
- Priority per cycle: rst > load > en > hold.
- load: count := min(load_val, limit); evt=0. en is ignored in that cycle.
- en=0 and load=0: count holds; evt=0.
- Arithmetic: internal sums are WIDTH+1 bits; step is zero-extended to WIDTH+1.
- Out-of-range state (limit lowered so count > limit) with en=1: count := limit in SAT mode, 0 in WRAP mode; evt=1. The step is not applied that cycle.
- UP, in range, s = count+step:
  - s <= limit: count := s, evt=0.
  - s > limit, WRAP: r = s-(limit+1); count := r if r <= limit, else limit; evt=1.
  - s > limit, SAT: count := limit; evt=1.
- DOWN, in range:
  - step <= count: count := count-step, evt=0.
  - step > count, WRAP: d = step-count; count := limit+1-d if d <= limit+1, else 0; evt=1.
  - step > count, SAT: count := 0; evt=1.
- step=0 with en=1: count unchanged, evt=0.
- Holding at a boundary in SAT mode, e.g. count==limit with up and step>0, repeats evt=1 every enabled cycle.
- limit=0: count stays 0. Any enabled nonzero step gives evt=1.
- evt is registered alongside count and appears in the same cycle as the new count value.
- evt_sticky: set when the registered evt would be 1, cleared by clr_evt. Set wins over a simultaneous clear.
- Inputs up, step, mode and limit may change every cycle; each cycle uses the current values. There is no internal state machine beyond count and the flags.

Decomposition:
- Shared package seq_pkg holds:
  - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e
  - localparam defaults for WIDTH and STEP_W
- One combinational sub-module, seq_cnt_next, computes next_count and evt_next from (count, step, up, mode, limit). The top level holds the registers, load/enable priority and sticky logic.

Test Plan:
1. rst=1 for 2 cycles with en=1, load=1 -> count=0, evt=0, evt_sticky=0; at_min=1.
2. WRAP, limit=9, step=3, up, en for 5 cycles from 0 -> count 3,6,9,2,5; evt=1 only on the 9->2 cycle; evt_sticky=1 afterwards.
3. SAT, limit=200, load 198, step=5 down then up: down 198->193; up 193->198->200->200 with evt on the last two cycles; down from 2 with step=5 -> 0, evt=1.
4. Load 250 with limit=100 -> count=100, at_max=1. Lower limit to 50 with en=1: WRAP gives count=0, evt=1; repeating with SAT gives count=50, evt=1.
5. WRAP, limit=4, count=1, down, step=15 -> d=14 > 5, so count=0, evt=1. Then step=0 -> hold, evt=0.
6. Same cycle load=1, en=1, clr_evt=1 while evt fires from a prior step -> load wins (count=load_val clamped, evt=0); sticky clears only if no evt was registered that cycle. Then rst mid-count -> count=0 on the next edge.
